toggle_activity_monitor: RTL and testbench
==========================================

// Module: toggle_activity_monitor
// PURPOSE
//  Run-time trust monitor that watches a wide datapath bus, such as the AES round state.
//  It measures switching activity as the Hamming distance between consecutive samples and
//  sums it over fixed windows. It raises a sticky alarm when activity stays abnormally high
//  for several consecutive windows, which is the signature of a rotating power-burn payload.
//  Instantiated beside the AES core; its alarm feeds the chip-level security status.
// PARAMETERS
//  WIDTH     128    monitored bus width; must be 128 in this revision
//  WIN_LOG2  8      window length = 2**WIN_LOG2 accumulated Hamming distances
//  THRESH    16384  window total strictly greater than THRESH counts as a hot window
//  PERSIST   4      consecutive hot windows needed to set the alarm (1..15)
// PORTS
//  clk        in   1      system clock, all logic on the rising edge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      monitor enable; bus is sampled only while en=1
//  bus        in   128    monitored data (e.g. AES state register)
//  alarm_clr  in   1      one-cycle pulse that clears a sticky alarm
//  win_count  out  16     total of the last completed window (WIN_LOG2+8 bits)
//  win_valid  out  1      one-cycle pulse when win_count updates
//  hot_streak out  4      current run of consecutive hot windows, saturates at PERSIST
//  alarm      out  1      sticky alarm
// BEHAVIOUR
//  - Reset: all outputs 0, sample registers 0, window counter 0, FSM in IDLE.
//  - FSM states IDLE, PRIME, RUN.
//    - IDLE->PRIME when en=1. PRIME captures the first sample, with no HD; then ->RUN.
//    - RUN->IDLE when en=0. The partial window accumulator and window counter are held.
//    - On re-enable the FSM passes through PRIME again, so a stale previous sample never
//      produces an HD. The held partial window then resumes.
//  - Pipeline: cur<=bus, prev<=cur each enabled cycle.
//    - hd = popcount(cur^prev), 0..128, 8 bits, computed in 2 registered stages.
//    - HD of samples captured on edges k-1 and k is added to the accumulator on edge k+2.
//    - Pipeline contents still drain into the accumulator after en falls.
//  - Window: accumulator is WIN_LOG2+8 bits and cannot overflow (max 128*256 = 32768).
//    - After 2**WIN_LOG2 HDs are added, the completed total is written to win_count on
//      the next edge and win_valid pulses for 1 cycle.
//    - The accumulator restarts with the next HD and no HD is lost at the window boundary.
//  - Hot window (win_count > THRESH): hot_streak increments, saturating at PERSIST.
//    A cool window sets hot_streak to 0.
//  - alarm sets on the edge where hot_streak reaches PERSIST. It stays 1 until alarm_clr.
//  - alarm_clr also zeroes hot_streak.
//  - alarm_clr in the same cycle as a set condition: set wins, so alarm stays 1.
//  - rst at any time, including mid-window or mid-pipeline: returns everything to reset
//    values on that edge; no partial window is reported.
// STRUCTURE
//  - Shared package: monitor FSM state enum, WIDTH/WIN_LOG2-derived width constants, and
//    the default THRESH and PERSIST values.
//  - Sub-module: popcount128_pipe. Inputs a[127:0]; output cnt[7:0].
//    - Stage 1: 16 registered 8-bit popcounts.
//    - Stage 2: registered adder tree.
//    - Latency 2; no reset is required on the datapath, only valid tracking.
//  - Top level: sample registers, FSM, window counter, accumulator, streak logic, alarm.
// TESTING
//  1. Constant bus 0, en=1 for 4 windows -> win_count=0 each window,
//     win_valid every 256 cycles, alarm=0.
//  2. bus = 0xaaaa..aa rotated right 1 bit every cycle (full toggle)
//     -> win_count=32768 each window, hot_streak 1..4, alarm=1 at 4th win_valid.
//  3. Single bit toggling each cycle -> win_count=256, hot_streak=0, alarm never set.
//  4. Scenario 2 with alarm_clr on the same cycle as the 4th win_valid -> alarm=1.
//     A later clear while the bus is held constant -> alarm=0, hot_streak=0.
//  5. Scenario 2 with en dropped for 50 cycles mid-window
//     -> window total still 32768 and no HD from the stale sample pair.
//     The pause only extends the window.
//  6. rst pulse mid-window during scenario 2 -> next edge all outputs 0.
//     The first win_valid comes 256 HDs after re-priming.

Source files
------------

// File: rtl/toggle_activity_monitor_pkg.sv
// Shared types and width constants for the toggle activity monitor.
package toggle_activity_monitor_pkg;

    localparam int unsigned WIDTH        = 128;
    localparam int unsigned WIN_LOG2     = 8;
    localparam int unsigned HD_W         = 8;
    localparam int unsigned ACC_W        = WIN_LOG2 + 8;
    localparam int unsigned STREAK_W     = 4;
    localparam int unsigned SLICE_W      = 8;
    localparam int unsigned SLICES       = WIDTH / SLICE_W;
    localparam int unsigned SLICE_CNT_W  = 4;
    localparam int unsigned DEF_THRESH   = 16384;
    localparam int unsigned DEF_PERSIST  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [SLICE_CNT_W-1:0] popcount8(input logic [SLICE_W-1:0] x);
        logic [SLICE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            n = n + SLICE_CNT_W'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/toggle_activity_monitor_popcount128_pipe.sv
// Two-stage registered popcount of a 128-bit word with valid tracking.
module popcount128_pipe
    import toggle_activity_monitor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic              in_valid,
    output logic [HD_W-1:0]   cnt,
    output logic              out_valid
);

    logic [SLICE_CNT_W-1:0] part [SLICES];
    logic [HD_W-1:0]        sum_c;
    logic                   v1;

    // Stage 1: per-byte popcounts; datapath needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(SLICES); i++) begin
            part[i] <= popcount8(a[i*SLICE_W +: SLICE_W]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(SLICES); i++) begin
            sum_c = sum_c + HD_W'(part[i]);
        end
    end

    // Stage 2: registered sum.
    always_ff @(posedge clk) begin
        cnt <= sum_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Switching-activity trust monitor: windowed Hamming-distance totals with a sticky alarm.
module toggle_activity_monitor
    import toggle_activity_monitor_pkg::*;
#(
    parameter int unsigned THRESH  = DEF_THRESH,
    parameter int unsigned PERSIST = DEF_PERSIST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    bus,
    input  logic                alarm_clr,
    output logic [ACC_W-1:0]    win_count,
    output logic                win_valid,
    output logic [STREAK_W-1:0] hot_streak,
    output logic                alarm
);

    state_t                state;
    logic [WIDTH-1:0]      cur;
    logic                  hd_in_valid;
    logic                  hd_valid;
    logic [HD_W-1:0]       hd;
    logic [ACC_W-1:0]      acc;
    logic [WIN_LOG2-1:0]   hd_cnt;
    logic                  win_done;
    logic                  hot_c;
    logic                  set_c;
    logic [STREAK_W-1:0]   streak_next_c;

    // The HD of (bus, cur) enters the pipe on the edge that captures bus.
    assign hd_in_valid = (state == ST_RUN) && en;

    popcount128_pipe u_popcount (
        .clk       (clk),
        .rst       (rst),
        .a         (bus ^ cur),
        .in_valid  (hd_in_valid),
        .cnt       (hd),
        .out_valid (hd_valid)
    );

    // Monitor FSM; PRIME guarantees a fresh reference sample after every enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cur   <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (en) state <= ST_PRIME;
                ST_PRIME: begin
                    if (en) begin
                        cur   <= bus;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (en) cur <= bus;
                    else    state <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hot_c         = 32'(acc) > THRESH;
        streak_next_c = '0;
        if (hot_c) begin
            if (hot_streak == STREAK_W'(PERSIST)) streak_next_c = hot_streak;
            else                                  streak_next_c = hot_streak + STREAK_W'(1);
        end
        set_c = win_done && hot_c && (streak_next_c == STREAK_W'(PERSIST));
    end

    // Window accumulation; the first HD of the next window lands on the report edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            hd_cnt     <= '0;
            win_done   <= 1'b0;
            win_count  <= '0;
            win_valid  <= 1'b0;
            hot_streak <= '0;
            alarm      <= 1'b0;
        end else begin
            win_valid <= win_done;
            win_done  <= hd_valid && (hd_cnt == '1);
            if (hd_valid) hd_cnt <= hd_cnt + WIN_LOG2'(1);

            if (win_done) begin
                win_count <= acc;
                acc       <= hd_valid ? ACC_W'(hd) : '0;
            end else if (hd_valid) begin
                acc <= acc + ACC_W'(hd);
            end

            if (set_c) begin
                alarm      <= 1'b1;
                hot_streak <= STREAK_W'(PERSIST);
            end else if (alarm_clr) begin
                alarm      <= 1'b0;
                hot_streak <= '0;
            end else if (win_done) begin
                hot_streak <= streak_next_c;
            end
        end
    end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Randomized and directed bench for toggle_activity_monitor against an edge-level reference model.
module tb_toggle_activity_monitor;

    localparam int THRESH  = 16384;
    localparam int PERSIST = 4;
    localparam int WIN     = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         alarm_clr = 1'b0;
    logic [127:0] bus = '0;
    logic [15:0]  win_count;
    logic         win_valid;
    logic [3:0]   hot_streak;
    logic         alarm;

    int errors = 0;
    int checks = 0;

    toggle_activity_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .alarm_clr  (alarm_clr),
        .win_count  (win_count),
        .win_valid  (win_valid),
        .hot_streak (hot_streak),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           t = 0;
    int           run_len = 0;
    logic [127:0] last_sample = '0;
    int           add_val[$];
    int           add_time[$];
    int           m_sum = 0;
    int           m_n = 0;
    bit           rep_due = 1'b0;
    int           rep_val = 0;
    int           m_reports = 0;
    int           exp_count = 0;
    bit           exp_valid = 1'b0;
    int           exp_streak = 0;
    bit           exp_alarm = 1'b0;

    bit           armed = 1'b0;
    int           sc_total = -1;
    int           obs_windows = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One rising edge of the specified behaviour, given the inputs held across it.
    task automatic model_edge(input bit r, input bit e, input logic [127:0] b, input bit c);
        int ns;
        bit hot;
        t++;
        if (r) begin
            run_len = 0; last_sample = '0;
            add_val.delete(); add_time.delete();
            m_sum = 0; m_n = 0; rep_due = 1'b0; rep_val = 0; m_reports = 0;
            exp_count = 0; exp_valid = 1'b0; exp_streak = 0; exp_alarm = 1'b0;
            return;
        end
        exp_valid = rep_due;
        if (rep_due) begin
            m_reports++;
            exp_count = rep_val;
            hot = rep_val > THRESH;
            ns  = hot ? ((exp_streak + 1 > PERSIST) ? PERSIST : exp_streak + 1) : 0;
            if (hot && ns == PERSIST) begin
                exp_alarm = 1'b1; exp_streak = PERSIST;
            end else if (c) begin
                exp_alarm = 1'b0; exp_streak = 0;
            end else begin
                exp_streak = ns;
            end
        end else if (c) begin
            exp_alarm = 1'b0; exp_streak = 0;
        end
        rep_due = 1'b0;
        while (add_time.size() > 0 && add_time[0] == t) begin
            m_sum += add_val.pop_front();
            void'(add_time.pop_front());
            m_n++;
            if (m_n == WIN) begin
                rep_due = 1'b1; rep_val = m_sum; m_sum = 0; m_n = 0;
            end
        end
        if (e) begin
            run_len++;
            if (run_len == 2) begin
                last_sample = b;
            end else if (run_len > 2) begin
                add_val.push_back($countones(b ^ last_sample));
                add_time.push_back(t + 2);
                last_sample = b;
            end
        end else begin
            run_len = 0;
        end
    endtask

    task automatic drive(input bit r, input bit e, input logic [127:0] b, input bit c);
        @(negedge clk);
        if (armed) begin
            check_eq("win_valid", 32'(win_valid), 32'(exp_valid));
            check_eq("win_count", 32'(win_count), 32'(exp_count));
            check_eq("hot_streak", 32'(hot_streak), 32'(exp_streak));
            check_eq("alarm", 32'(alarm), 32'(exp_alarm));
            if (win_valid === 1'b1) begin
                obs_windows++;
                if (sc_total >= 0) check_eq("window_total", 32'(win_count), 32'(sc_total));
            end
        end
        rst = r; en = e; bus = b; alarm_clr = c;
        model_edge(r, e, b, c);
    endtask

    task automatic reset_dut();
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        armed = 1'b1;
        obs_windows = 0;
    endtask

    initial begin
        logic [127:0] pat;
        logic [127:0] mask;
        logic [127:0] aa;
        int mode;
        bit c;

        aa = {16{8'haa}};

        // 1: constant bus
        reset_dut();
        sc_total = 0;
        repeat (1034) drive(1'b0, 1'b1, '0, 1'b0);
        check_eq("sc1_windows", 32'(obs_windows), 32'd4);
        check_eq("sc1_alarm", 32'(alarm), 32'd0);

        // 2: full toggle via rotating 0xaa pattern
        reset_dut();
        sc_total = 32768;
        pat = aa;
        repeat (1034) begin
            drive(1'b0, 1'b1, pat, 1'b0);
            pat = {pat[0], pat[127:1]};
        end
        check_eq("sc2_windows", 32'(obs_windows), 32'd4);
        check_eq("sc2_alarm", 32'(alarm), 32'd1);
        check_eq("sc2_streak", 32'(hot_streak), 32'd4);

        // 3: single bit toggling
        reset_dut();
        sc_total = 256;
        pat = '0;
        repeat (778) begin
            drive(1'b0, 1'b1, pat, 1'b0);
            pat[0] = ~pat[0];
        end
        check_eq("sc3_windows", 32'(obs_windows), 32'd3);
        check_eq("sc3_alarm", 32'(alarm), 32'd0);
        check_eq("sc3_streak", 32'(hot_streak), 32'd0);

        // 4: clear coinciding with the alarm set, then a real clear
        reset_dut();
        sc_total = 32768;
        pat = aa;
        for (int i = 0; i < 2000 && m_reports < 4; i++) begin
            c = rep_due && (m_reports == 3);
            drive(1'b0, 1'b1, pat, c);
            pat = {pat[0], pat[127:1]};
        end
        check_eq("sc4_reached", 32'(m_reports), 32'd4);
        drive(1'b0, 1'b1, pat, 1'b0);
        check_eq("sc4_set_wins", 32'(alarm), 32'd1);
        sc_total = -1;
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, pat, i == 100);
        check_eq("sc4_cleared", 32'(alarm), 32'd0);
        check_eq("sc4_streak", 32'(hot_streak), 32'd0);

        // 5: enable dropped for 50 cycles mid-window
        reset_dut();
        sc_total = 32768;
        pat = aa;
        for (int i = 0; i < 1100; i++) begin
            drive(1'b0, !(i >= 100 && i < 150), pat, 1'b0);
            pat = {pat[0], pat[127:1]};
        end
        check_eq("sc5_windows", 32'(obs_windows), 32'd4);

        // 6: reset mid-window
        reset_dut();
        sc_total = 32768;
        pat = aa;
        for (int i = 0; i < 900; i++) begin
            drive(i == 300, 1'b1, pat, 1'b0);
            pat = {pat[0], pat[127:1]};
        end
        check_eq("sc6_windows", 32'(obs_windows), 32'd3);

        // 7: randomized activity, enables, clears and resets
        reset_dut();
        sc_total = -1;
        pat = rand128();
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % WIN == 0) mode = $urandom_range(0, 3);
            case (mode)
                0:       mask = rand128();
                1:       mask = rand128() | rand128();
                2:       mask = rand128() & rand128();
                default: mask = ~128'd0;
            endcase
            pat = pat ^ mask;
            drive($urandom_range(0, 1999) == 0, $urandom_range(0, 99) < 97, pat,
                  $urandom_range(0, 299) == 0);
        end
        drive(1'b0, 1'b0, pat, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
